// File: rtl/quad_pipe.sv
// Pipelined sum-of-squares unit c = Q(a*a + b*b) with valid/ready flow control.
// Define QUAD_SAT_EN to clamp overflowing results to all-ones and flag sat; otherwise results wrap.
`timescale 1ns/1ps

module quad_pipe #(
  parameter int IN_W   = 14,
  parameter int SIGNED = 0,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 2*IN_W+1,
  parameter int RND    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] c,
  output logic             sat
);

  localparam int FW = 2*IN_W+1;
  localparam int unsigned RS = (SHIFT > 0) ? SHIFT-1 : 0;
  localparam logic [FW:0] RC = (RND != 0 && SHIFT > 0) ? ({{FW{1'b0}}, 1'b1} << RS) : '0;

  if (IN_W < 2 || IN_W > 32 || OUT_W < 1 || SHIFT < 0 || SHIFT > 2*IN_W) begin : g_bad_params
    $error("quad_pipe: illegal parameter combination");
  end

  logic                en;
  logic                v1, v2, v3, v4;
  logic [IN_W-1:0]     a1, b1;
  logic [2*IN_W-1:0]   sqa, sqb;
  logic [FW:0]         s3;
  logic [OUT_W-1:0]    c_q;

  logic [2*IN_W-1:0]   ax, bx, sqa_n, sqb_n;
  logic [FW:0]         sum_n, r;
  logic                ovf;
  logic [OUT_W-1:0]    c_n;

  assign en        = out_ready | ~v4;
  assign in_ready  = en;
  assign out_valid = v4;
  assign c         = c_q;

  // Squares are taken modulo 2^(2*IN_W); the true square always fits, so
  // sign extension alone gives the correct signed result.
  always_comb begin
    ax    = {{IN_W{(SIGNED != 0) & a1[IN_W-1]}}, a1};
    bx    = {{IN_W{(SIGNED != 0) & b1[IN_W-1]}}, b1};
    sqa_n = ax * ax;
    sqb_n = bx * bx;
    sum_n = (FW+1)'(sqa) + (FW+1)'(sqb) + RC;
    r     = s3 >> SHIFT;
  end

  if (OUT_W >= FW+1) begin : g_no_ovf
    assign ovf = 1'b0;
  end else begin : g_ovf
    assign ovf = |(r >> OUT_W);
  end

`ifdef QUAD_SAT_EN
  logic sat_q;
  assign c_n = ovf ? '1 : OUT_W'(r);
  assign sat = sat_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf ^ (^r);
  assign c_n = OUT_W'(r);
  assign sat = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      v4  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      sqa <= '0;
      sqb <= '0;
      s3  <= '0;
      c_q <= '0;
`ifdef QUAD_SAT_EN
      sat_q <= 1'b0;
`endif
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
      if (in_valid) begin
        a1 <= a;
        b1 <= b;
      end
      if (v1) begin
        sqa <= sqa_n;
        sqb <= sqb_n;
      end
      if (v2) s3 <= sum_n;
      if (v3) begin
        c_q <= c_n;
`ifdef QUAD_SAT_EN
        sat_q <= ovf;
`endif
      end
    end
  end

endmodule
